alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the bit-slice ALU array (AND/OR/ADD/SUB/MOV/... slices).
- Captures the WIDTH-bit result plus carry-out and overflow from the slice chain.
- Computes and holds status flags Z/N/C/V.
- Presents results to the consumer through a 2-entry valid/ready buffer, so ALU issue never stalls on a single-cycle consumer hiccup.

Parameters:
- WIDTH, 8, datapath width; equals the number of 1-bit slices.
- OPW, 3, opcode width.
- CNTW, 16, width of the retired-result counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result present this cycle
- in_ready  out  1  stage can accept this cycle
- in_result  in  WIDTH  slice-chain result bits
- in_cout  in  1  carry-out of MSB slice
- in_ovf  in  1  signed overflow from MSB slice
- in_op  in  OPW  opcode that produced the result
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_result  out  WIDTH  head result
- out_flags  out  4  head flags {Z,N,C,V}
- status_flags  out  4  architectural flag register {Z,N,C,V}
- retired  out  CNTW  count of results accepted by the consumer

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising clk edge.
- Reset values: count=0, rd/wr pointers=0, out_valid=0, out_result=0, out_flags=0, status_flags=0, retired=0. Reset mid-operation discards both entries; in_ready=1 in the cycle after reset deasserts.
- Storage: 2-entry circular buffer {result, flags}; count in 0..2.
  - 1-bit pointers wrap 1->0.
  - Output fields are driven from the head entry.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2), from registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - in_result, in_cout, in_ovf and in_op are ignored when in_valid=0.
- Latency: a pushed result appears on the outputs one cycle later when the buffer was empty. Sustained throughput is 1 result/cycle when out_ready=1.
- Simultaneous events:
  - push & pop at count=1: count stays 1, new entry becomes head next cycle.
  - push at count=2 is impossible because in_ready=0.
  - pop at count=0 is impossible because out_valid=0.
  - The head is stable while out_valid=1 & out_ready=0.
- Flag computation, evaluated at push time against status_flags:
  - Z = (in_result == 0).
  - N = in_result[WIDTH-1].
  - For ADD and SUB: C = in_cout, V = in_ovf.
  - For all other ops (AND, OR, XOR, NOT, MOV, SLT): C and V keep their current status_flags values.
  - status_flags updates on every push, in push order, and equals the flags stored with the newest entry.
- retired increments by 1 on each pop and wraps from all-ones to 0.

FSM:
- EMPTY(count 0)
  - push -> ONE
- ONE(count 1)
  - push & !pop -> FULL
  - pop & !push -> EMPTY
  - otherwise stays ONE
- FULL(count 2)
  - pop -> ONE

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_MOV=4, OP_NOT=5, OP_XOR=6, OP_SLT=7;
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- One sub-module: alu_flag_gen, combinational {in_result, in_cout, in_ovf, in_op, status_flags} -> new flags.
- Buffer and counter logic stay in the top module.

Test Plan:
- Reset, then OP_ADD with in_result=8'h00, in_cout=1, in_ovf=0 and out_ready=1 -> next cycle out_valid=1, out_result=8'h00, out_flags=4'b1010; retired=1 after the pop.
- OP_ADD with in_cout=1, then OP_MOV with in_result=8'h80, in_cout=0, in_ovf=1 -> MOV entry has out_flags=4'b0110 (C retained, V retained as 0, not 1); status_flags=4'b0110.
- Hold out_ready=0 and push 8'h11, 8'h22, 8'h33 on consecutive cycles:
  - in_ready drops after the second push, and 8'h33 is held off until space frees;
  - raising out_ready then pops in order 11, 22, 33;
  - no entry is lost or duplicated.
- out_ready=1 and in_valid=1 for 10 cycles with results 1..10 -> one pop per cycle, count never exceeds 1, retired=10.
- Assert rst for one cycle while FULL -> next cycle out_valid=0, status_flags=0, retired=0, in_ready=1; the stale entries never appear.
- Preload retired to 16'hFFFF via 65535 pops, then one more pop -> retired=16'h0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and buffer state type for the
// ALU result stage and its flag generator.
package alu_pkg;

  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_MOV = 4;
  localparam int OP_NOT = 5;
  localparam int OP_XOR = 6;
  localparam int OP_SLT = 7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int NUM_FLAGS = 4;
  localparam int DEPTH     = 2;

  // State names mirror the buffer occupancy (0, 1 or 2 entries).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // Only the arithmetic ops own the carry and overflow flags.
  function automatic logic op_is_arith(input int unsigned op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V generator; C and V fall back to the architectural
// flags for logical and move ops.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_cout,
  input  logic             i_ovf,
  input  logic [OPW-1:0]   i_op,
  input  logic [3:0]       i_status_flags,
  output logic [3:0]       o_flags
);

  logic w_arith;

  assign w_arith = op_is_arith(int'(unsigned'(i_op)));

  always_comb begin
    o_flags         = i_status_flags;
    o_flags[FLAG_Z] = (i_result == '0);
    o_flags[FLAG_N] = i_result[WIDTH-1];
    if (w_arith) begin
      o_flags[FLAG_C] = i_cout;
      o_flags[FLAG_V] = i_ovf;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: computes flags at push time and presents
// results through a 2-entry valid/ready buffer.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_ovf,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       status_flags,
  output logic [CNTW-1:0]  retired
);

  buf_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [3:0]       r_status_flags;
  logic [CNTW-1:0]  r_retired;
  logic [WIDTH-1:0] r_mem_result [DEPTH];
  logic [3:0]       r_mem_flags  [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_new_flags;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  alu_flag_gen #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_flag_gen (
    .i_result       (in_result),
    .i_cout         (in_cout),
    .i_ovf          (in_ovf),
    .i_op           (in_op),
    .i_status_flags (r_status_flags),
    .o_flags        (w_new_flags)
  );

  // Handshake outputs are registered alongside the state, so in_ready
  // never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_push) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_status_flags <= '0;
      r_retired      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr       <= ~r_wr_ptr;
        r_status_flags <= w_new_flags;
      end
      if (w_pop) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Entries are cleared on reset so the head reads zero afterwards.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem_result[gi] <= '0;
          r_mem_flags[gi]  <= '0;
        end else if (w_push && (r_wr_ptr == gi[0])) begin
          r_mem_result[gi] <= in_result;
          r_mem_flags[gi]  <= w_new_flags;
        end
      end
    end
  endgenerate

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_result   = r_mem_result[r_rd_ptr];
  assign out_flags    = r_mem_flags[r_rd_ptr];
  assign status_flags = r_status_flags;
  assign retired      = r_retired;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int CNTW  = 16;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_MOV = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_cout;
  logic             in_ovf;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [3:0]       status_flags;
  logic [CNTW-1:0]  retired;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .WIDTH (WIDTH),
    .OPW   (OPW),
    .CNTW  (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_cout      (in_cout),
    .in_ovf       (in_ovf),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .status_flags (status_flags),
    .retired      (retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] res,
                       input logic c, input logic o);
    in_valid  = v;
    in_op     = op;
    in_result = res;
    in_cout   = c;
    in_ovf    = o;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_status", 32'(status_flags), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // ADD giving zero with carry out: Z=1 N=0 C=1 V=0
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, OP_AND, 8'hFF, 1'b0, 1'b1);
    check("add0_valid", 32'(out_valid), 32'd1);
    check("add0_result", 32'(out_result), 32'h00);
    check("add0_flags", 32'(out_flags), 32'hA);
    check("add0_status", 32'(status_flags), 32'hA);
    tick();
    check("add0_retired", 32'(retired), 32'd1);
    check("add0_drained", 32'(out_valid), 32'd0);
    $display("[TB] txn add0 result=%0h flags=a retired=%0d", 8'h00, retired);

    // ADD sets C, then MOV keeps C=1 and V=0 despite in_ovf=1
    drive(1'b1, OP_ADD, 8'h05, 1'b1, 1'b0);
    tick();
    check("add5_flags", 32'(out_flags), 32'h2);
    drive(1'b1, OP_MOV, 8'h80, 1'b0, 1'b1);
    tick();
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    check("mov_result", 32'(out_result), 32'h80);
    check("mov_flags", 32'(out_flags), 32'h6);
    check("mov_status", 32'(status_flags), 32'h6);
    tick();
    check("mov_retired", 32'(retired), 32'd3);
    $display("[TB] txn mov result=80 flags=6 retired=%0d", retired);

    // Back-pressure: fill, hold off third push, then drain in order
    out_ready = 1'b0;
    drive(1'b1, OP_MOV, 8'h11, 1'b0, 1'b0);
    tick();
    check("bp_ready_one", 32'(in_ready), 32'd1);
    drive(1'b1, OP_MOV, 8'h22, 1'b0, 1'b0);
    tick();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, OP_MOV, 8'h33, 1'b0, 1'b0);
    tick();
    tick();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_head_stable", 32'(out_result), 32'h11);
    check("bp_head_flags", 32'(out_flags), 32'h2);
    check("bp_status", 32'(status_flags), 32'h2);
    out_ready = 1'b1;
    tick();
    check("bp_pop_22", 32'(out_result), 32'h22);
    check("bp_ready_freed", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    check("bp_pop_33", 32'(out_result), 32'h33);
    check("bp_valid_33", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_retired", 32'(retired), 32'd6);
    $display("[TB] txn backpressure 11,22,33 retired=%0d", retired);

    // Streaming 1..10 at one per cycle
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, OP_AND, 8'(i), 1'b0, 1'b0);
      tick();
      check($sformatf("stream_result_%0d", i), 32'(out_result), 32'(i));
      check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
      $display("[TB] txn stream result=%0h valid=%0d", out_result, out_valid);
    end
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    tick();
    check("stream_retired", 32'(retired), 32'd16);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'hAA, 1'b1, 1'b1);
    tick();
    drive(1'b1, OP_ADD, 8'hBB, 1'b1, 1'b1);
    tick();
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    check("full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_status", 32'(status_flags), 32'd0);
    check("mrst_retired", 32'(retired), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    check("mrst_result", 32'(out_result), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("mrst_no_stale", 32'(out_valid), 32'd0);
    check("mrst_no_retire", 32'(retired), 32'd0);
    $display("[TB] txn midreset valid=%0d retired=%0d", out_valid, retired);

    // Counter wrap: 65535 pops reach all-ones, one more wraps to zero
    drive(1'b1, OP_ADD, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) tick();
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    tick();
    check("wrap_ffff", 32'(retired), 32'hFFFF);
    $display("[TB] txn preload retired=%0h", retired);
    drive(1'b1, OP_ADD, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b0, OP_AND, 8'h00, 1'b0, 1'b0);
    tick();
    check("wrap_zero", 32'(retired), 32'h0000);
    $display("[TB] txn wrap retired=%0h", retired);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
